// File: rtl/details.sv
// rtl/details.sv - shared datapath package: bus source select codes and default widths
package details;

    localparam int DEF_WIDTH    = 12;
    localparam int DEF_IR_WIDTH = 8;

    typedef enum logic [3:0] {
        DMem_sel = 4'd0,
        R_sel    = 4'd1,
        IR_sel   = 4'd2,
        RL_sel   = 4'd3,
        RC_sel   = 4'd4,
        RP_sel   = 4'd5,
        RQ_sel   = 4'd6,
        R1_sel   = 4'd7,
        AC_sel   = 4'd8,
        idle     = 4'd9
    } bus_in_sel_t;

endpackage

// File: rtl/multiplexer.sv
// rtl/multiplexer.sv - registered bus-source multiplexer driving the shared internal bus
module multiplexer
    import details::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int IR_WIDTH = DEF_IR_WIDTH
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic [3:0]          selectIn,
    input  logic [WIDTH-1:0]    DMem,
    input  logic [WIDTH-1:0]    R,
    input  logic [IR_WIDTH-1:0] IR,
    input  logic [WIDTH-1:0]    RL,
    input  logic [WIDTH-1:0]    RC,
    input  logic [WIDTH-1:0]    RP,
    input  logic [WIDTH-1:0]    RQ,
    input  logic [WIDTH-1:0]    R1,
    input  logic [WIDTH-1:0]    AC,
    output logic [WIDTH-1:0]    busOut,
    output logic                selErr
);

    logic [WIDTH-1:0] bus_d, bus_q;
    logic             sel_err_d, sel_err_q;
    logic [WIDTH-1:0] ir_ext;

    // Slice assignment keeps zero-extension legal even when IR_WIDTH == WIDTH.
    always_comb begin
        ir_ext                 = '0;
        ir_ext[IR_WIDTH-1:0]   = IR;
        bus_d                  = '0;
        sel_err_d              = 1'b0;
        case (bus_in_sel_t'(selectIn))
            DMem_sel: bus_d = DMem;
            R_sel:    bus_d = R;
            IR_sel:   bus_d = ir_ext;
            RL_sel:   bus_d = RL;
            RC_sel:   bus_d = RC;
            RP_sel:   bus_d = RP;
            RQ_sel:   bus_d = RQ;
            R1_sel:   bus_d = R1;
            AC_sel:   bus_d = AC;
            idle:     bus_d = '0;
            default: begin
                bus_d     = '0;
                sel_err_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            bus_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            bus_q     <= bus_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign busOut = bus_q;
    assign selErr = sel_err_q;

endmodule

// File: tb/tb_multiplexer.sv
// tb/tb_multiplexer.sv - directed and random checks of the registered bus multiplexer
module tb_multiplexer;
    import details::*;

    logic        clk;
    logic        rstN;
    logic [3:0]  selectIn;
    logic [11:0] DMem, R, RL, RC, RP, RQ, R1, AC;
    logic [7:0]  IR;
    logic [11:0] busOut;
    logic        selErr;

    int n_checks = 0;
    int n_fail   = 0;

    multiplexer #(.WIDTH(12), .IR_WIDTH(8)) dut (
        .clk(clk), .rstN(rstN), .selectIn(selectIn),
        .DMem(DMem), .R(R), .IR(IR), .RL(RL), .RC(RC), .RP(RP),
        .RQ(RQ), .R1(R1), .AC(AC), .busOut(busOut), .selErr(selErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults();
        DMem = 12'd10; R = 12'd11; RL = 12'd12; RC = 12'd13; RP = 12'd14;
        RQ = 12'd15; R1 = 12'd16; AC = 12'd17; IR = 8'd18;
    endtask

    function automatic logic [12:0] ref_model(input logic [3:0] s,
        input logic [11:0] dm, r, rl, rc, rp, rq, r1, ac, input logic [7:0] ir);
        logic [12:0] v;
        // {selErr, busOut}
        if (s == 4'd0)      v = {1'b0, dm};
        else if (s == 4'd1) v = {1'b0, r};
        else if (s == 4'd2) v = {5'b0, ir};
        else if (s == 4'd3) v = {1'b0, rl};
        else if (s == 4'd4) v = {1'b0, rc};
        else if (s == 4'd5) v = {1'b0, rp};
        else if (s == 4'd6) v = {1'b0, rq};
        else if (s == 4'd7) v = {1'b0, r1};
        else if (s == 4'd8) v = {1'b0, ac};
        else if (s == 4'd9) v = 13'd0;
        else                v = {1'b1, 12'd0};
        return v;
    endfunction

    logic [11:0] sweep_exp [10];
    logic [12:0] exp_v;

    initial begin
        sweep_exp = '{12'd10, 12'd11, 12'd18, 12'd12, 12'd13, 12'd14, 12'd15, 12'd16, 12'd17, 12'd0};
        set_defaults();
        rstN     = 1'b0;
        selectIn = 4'd8;
        #2;
        check("reset_bus", busOut, 12'd0);
        check("reset_err", {11'd0, selErr}, 12'd0);
        tick();
        check("reset_held_bus", busOut, 12'd0);
        rstN = 1'b1;

        for (int i = 0; i < 10; i++) begin
            selectIn = 4'(i);
            tick();
            check($sformatf("sweep_bus_%0d", i), busOut, sweep_exp[i]);
            check($sformatf("sweep_err_%0d", i), {11'd0, selErr}, 12'd0);
        end

        IR = 8'hFF; selectIn = 4'd2;
        tick();
        check("ir_zero_ext", busOut, 12'h0FF);
        IR = 8'd18;

        selectIn = 4'd10;
        tick();
        check("illegal10_bus", busOut, 12'd0);
        check("illegal10_err", {11'd0, selErr}, 12'd1);
        selectIn = 4'd15;
        tick();
        check("illegal15_bus", busOut, 12'd0);
        check("illegal15_err", {11'd0, selErr}, 12'd1);
        selectIn = 4'd8;
        tick();
        check("after_illegal_bus", busOut, 12'd17);
        check("after_illegal_err", {11'd0, selErr}, 12'd0);

        #2 rstN = 1'b0;
        #1;
        check("midreset_bus", busOut, 12'd0);
        check("midreset_err", {11'd0, selErr}, 12'd0);
        selectIn = 4'd1;
        #2 rstN = 1'b1;
        tick();
        check("post_reset_bus", busOut, 12'd11);

        selectIn = 4'd6;
        tick();
        check("track_old", busOut, 12'd15);
        RQ = 12'd4095;
        tick();
        check("track_new", busOut, 12'd4095);

        for (int i = 0; i < 120; i++) begin
            selectIn = 4'($urandom_range(0, 15));
            DMem = 12'($urandom); R  = 12'($urandom); RL = 12'($urandom);
            RC   = 12'($urandom); RP = 12'($urandom); RQ = 12'($urandom);
            R1   = 12'($urandom); AC = 12'($urandom); IR = 8'($urandom);
            exp_v = ref_model(selectIn, DMem, R, RL, RC, RP, RQ, R1, AC, IR);
            tick();
            check($sformatf("rand_bus_%0d", i), busOut, exp_v[11:0]);
            check($sformatf("rand_err_%0d", i), {11'd0, selErr}, {11'd0, exp_v[12]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multiplexer.md
Name: multiplexer

Overview:
- Registered bus-source multiplexer for the processor datapath.
- Selects one of nine register/memory sources onto the shared internal bus according to the control unit's bus-input select code.
- The selected value appears on busOut one clock after the select is applied.
- IR is narrower than the bus and is zero-extended.

Parameters:
- WIDTH, 12, data-bus width in bits; width of busOut and of every full-width source.
- IR_WIDTH, 8, instruction-register width; must satisfy 1 <= IR_WIDTH <= WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rstN  input  1  reset; asynchronous, active-low.
- selectIn  input  4 (bus_in_sel_t)  bus source select code.
- DMem  input  WIDTH  data-memory read data.
- R  input  WIDTH  R register.
- IR  input  IR_WIDTH  instruction register.
- RL  input  WIDTH  RL register.
- RC  input  WIDTH  RC register.
- RP  input  WIDTH  RP register.
- RQ  input  WIDTH  RQ register.
- R1  input  WIDTH  R1 register.
- AC  input  WIDTH  accumulator.
- busOut  output  WIDTH  registered bus value.
- selErr  output  1  registered flag; high when the select code captured at the last edge was illegal (10..15).

Behaviour:
- Select encoding (bus_in_sel_t, 4 bits): DMem_sel=0, R_sel=1, IR_sel=2, RL_sel=3, RC_sel=4, RP_sel=5, RQ_sel=6, R1_sel=7, AC_sel=8, idle=9.
- Reset: while rstN=0, busOut=0 and selErr=0, asynchronously and independent of clk. Both are held until the first rising clk edge after rstN returns to 1.
- Each rising edge with rstN=1 captures the source chosen by the current selectIn and the current source data.
  - Codes 0..8: busOut <= the corresponding source.
  - IR_sel: busOut <= {(WIDTH-IR_WIDTH) zeros, IR}, i.e. zero-extended, never sign-extended.
  - idle (9): busOut <= 0; selErr <= 0.
  - Codes 10..15: busOut <= 0; selErr <= 1.
  - Codes 0..8: selErr <= 0.
- Latency: exactly one clock from selectIn/data to busOut. Back-to-back select changes every cycle are supported with no bubbles.
- Source data changing while selectIn is held is tracked one cycle later.
- selectIn containing X/Z is not a supported input. RTL uses a full case with a default branch equal to the illegal-code behaviour.
- No combinational path from any input to any output.
- Reset asserted mid-stream clears both outputs immediately. The first post-reset edge loads normally.

Decomposition:
- Shared package details holds:
  - typedef enum logic [3:0] bus_in_sel_t with the ten codes above.
  - Default WIDTH/IR_WIDTH constants.
- Both multiplexer and the control unit import details.
- A single flat module: one always_comb select/zero-extend block, one always_ff output register. No sub-module is warranted.

Test Plan:
- Use WIDTH=12, IR_WIDTH=8, DMem=10, R=11, RL=12, RC=13, RP=14, RQ=15, R1=16, AC=17, IR=18 for all scenarios.
- Sweep: selectIn=0..9, one per cycle -> one cycle later busOut = 10, 11, 18, 12, 13, 14, 15, 16, 17, 0; selErr=0 throughout.
- Zero-extension: IR=8'hFF, selectIn=IR_sel -> busOut=12'h0FF, not 12'hFFF.
- Illegal codes: selectIn=10, then 15 -> busOut=0 and selErr=1 after each edge. Next selectIn=AC_sel -> busOut=17, selErr=0.
- Reset: with busOut=17, drive rstN=0 between clock edges -> busOut=0 and selErr=0 immediately. Release rstN with selectIn=R_sel -> busOut=11 after the first edge.
- Data tracking: hold selectIn=RQ_sel and change RQ 15->4095 -> busOut=15, then 4095 one cycle after the change.
- Random: 100+ random selectIn/data cycles against a one-cycle-delayed reference model. busOut and selErr must match every cycle.
